// File: rtl/clk_switch_pkg.sv
// ============================================================================
// Module   : clk_switch_pkg
// Brief    : Shared types and helpers for the clock-source switch controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clk_switch_pkg;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_GATE_OFF   = 2'd1,
    S_WAIT_ALIVE = 2'd2,
    S_GATE_ON    = 2'd3
  } state_e;

  localparam int unsigned c_MAX_SRC = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } lsb_t;

  // Lowest-index set bit of a source mask; found=0 when the mask is empty.
  function automatic lsb_t find_lowest(input logic [c_MAX_SRC-1:0] v);
    lsb_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = c_MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.found = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_switch_ctrl_guard_timer.sv
// ============================================================================
// Module   : guard_timer
// Brief    : Loadable down-counter that saturates at zero and flags expiry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module guard_timer
  import clk_switch_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
// ============================================================================
// Module   : clk_switch_ctrl
// Brief    : Glitch-safe clock-source select sequencer with timeout/failover.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int NUM_SRC       = 2,
  parameter int SEL_W         = $clog2(NUM_SRC),
  parameter int DEFAULT_SRC   = 0,
  parameter int GUARD_CYC     = 4,
  parameter int LOCK_CYC      = 16,
  parameter int AUTO_FAILOVER = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  input  logic [SEL_W-1:0]   req_sel_i,
  output logic               req_ready_o,
  input  logic [NUM_SRC-1:0] src_alive_i,
  output logic [NUM_SRC-1:0] ce_out_o,
  output logic [SEL_W-1:0]   sel_cur_o,
  output logic               busy_o,
  output logic               switch_done_o,
  output logic               fault_o,
  output logic               failover_o
);

  localparam int c_CNT_MAX = (GUARD_CYC > LOCK_CYC) ? GUARD_CYC : LOCK_CYC;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_GUARD_LD  = c_CNT_W'(GUARD_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_LOCK_LD   = c_CNT_W'(LOCK_CYC);
  localparam logic [SEL_W-1:0]   c_DEF_SEL   = SEL_W'(DEFAULT_SRC);
  localparam logic [31:0]        c_NUM_SRC_U = NUM_SRC;

  function automatic logic [NUM_SRC-1:0] sel2oh(input logic [SEL_W-1:0] s);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (s == SEL_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   target_q, target_d;
  logic [SEL_W-1:0]   sel_cur_q, sel_cur_d;
  logic               timed_out_q, timed_out_d;
  logic [NUM_SRC-1:0] ce_q, ce_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic               failover_q, failover_d;

  logic               w_accept;
  logic               w_req_bad;
  logic               w_cur_alive;
  logic               w_tgt_alive;
  logic [NUM_SRC-1:0] w_cand;
  lsb_t               w_lsb;
  logic [SEL_W-1:0]   w_fo_sel;
  logic               w_expired;
  logic               w_load;
  logic [c_CNT_W-1:0] w_load_val;
  logic               w_timeout;
  logic               w_fo_launch;

  assign req_ready_o = (state_q == S_IDLE) && !rst;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_req_bad   = 32'(req_sel_i) >= c_NUM_SRC_U;
  assign w_cur_alive = |(src_alive_i & sel2oh(sel_cur_q));
  assign w_tgt_alive = |(src_alive_i & sel2oh(target_q));
  assign w_cand      = src_alive_i & ~sel2oh(sel_cur_q);
  assign w_lsb       = find_lowest(c_MAX_SRC'(w_cand));
  assign w_fo_sel    = SEL_W'(w_lsb.idx);

  // Every state entry reloads the timer with that state's dwell length.
  assign w_load = (state_d != state_q);
  always_comb begin
    w_load_val = '0;
    unique case (state_d)
      S_GATE_OFF:   w_load_val = c_GUARD_LD;
      S_WAIT_ALIVE: w_load_val = c_LOCK_LD;
      S_GATE_ON:    w_load_val = c_GUARD_LD;
      default:      w_load_val = '0;
    endcase
  end

  guard_timer #(
    .W (c_CNT_W)
  ) u_guard_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (w_load),
    .value_i   (w_load_val),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      target_q    <= c_DEF_SEL;
      sel_cur_q   <= c_DEF_SEL;
      timed_out_q <= 1'b0;
      ce_q        <= sel2oh(c_DEF_SEL);
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      failover_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      sel_cur_q   <= sel_cur_d;
      timed_out_q <= timed_out_d;
      ce_q        <= ce_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      failover_q  <= failover_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    timed_out_d = timed_out_q;
    w_timeout   = 1'b0;
    w_fo_launch = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_req_bad && (req_sel_i != sel_cur_q)) begin
            target_d    = req_sel_i;
            timed_out_d = 1'b0;
            state_d     = S_GATE_OFF;
          end
        end else if ((AUTO_FAILOVER != 0) && !w_cur_alive && w_lsb.found) begin
          target_d    = w_fo_sel;
          timed_out_d = 1'b0;
          w_fo_launch = 1'b1;
          state_d     = S_GATE_OFF;
        end
      end
      S_GATE_OFF: begin
        if (w_expired) state_d = S_WAIT_ALIVE;
      end
      S_WAIT_ALIVE: begin
        if (w_tgt_alive) begin
          state_d = S_GATE_ON;
        end else if (w_expired) begin
          // Dead target: fall back to re-enabling the source we came from.
          w_timeout   = 1'b1;
          target_d    = sel_cur_q;
          timed_out_d = 1'b1;
          state_d     = S_GATE_ON;
        end
      end
      S_GATE_ON: begin
        if (w_expired) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_cur_d = sel_cur_q;
    if ((state_q == S_GATE_ON) && (state_d == S_IDLE)) sel_cur_d = target_q;
    unique case (state_d)
      S_GATE_ON: ce_d = sel2oh(target_d);
      S_IDLE:    ce_d = sel2oh(sel_cur_d);
      default:   ce_d = '0;
    endcase
    busy_d     = (state_d != S_IDLE);
    done_d     = ((state_q == S_IDLE) && w_accept && !w_req_bad && (req_sel_i == sel_cur_q)) ||
                 ((state_q == S_GATE_ON) && (state_d == S_IDLE) && !timed_out_q);
    fault_d    = ((state_q == S_IDLE) && w_accept && w_req_bad) || w_timeout;
    failover_d = w_fo_launch;
  end

  assign ce_out_o      = ce_q;
  assign sel_cur_o     = sel_cur_q;
  assign busy_o        = busy_q;
  assign switch_done_o = done_q;
  assign fault_o       = fault_q;
  assign failover_o    = failover_q;

endmodule

`default_nettype wire
